// File: rtl/stack_pkg.sv
// Shared constants, op-code encoding and request decode for the parameterised LIFO stack.
package stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

    typedef struct packed {
        stack_op_e op;
        logic      overflow;
        logic      underflow;
    } stack_dec_t;

    // A simultaneous push+pop on an empty stack degrades to a plain push
    // and still reports the rejected pop.
    function automatic stack_dec_t decode_op(
        input logic push,
        input logic pop,
        input logic is_empty,
        input logic is_full
    );
        stack_dec_t dec;
        dec.op        = OP_IDLE;
        dec.overflow  = 1'b0;
        dec.underflow = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (is_full) dec.overflow = 1'b1;
                else         dec.op       = OP_PUSH;
            end
            2'b01: begin
                if (is_empty) dec.underflow = 1'b1;
                else          dec.op        = OP_POP;
            end
            2'b11: begin
                if (is_empty) begin
                    dec.op        = OP_PUSH;
                    dec.underflow = 1'b1;
                end else begin
                    dec.op = OP_REPLACE;
                end
            end
            default: dec.op = OP_IDLE;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack: pointer, op decode, registered pop data and error pulses.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] top_data,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    logic [AW:0]      sp_reg, sp_next;
    logic [WIDTH-1:0] read_data_reg, read_data_next;
    logic             overflow_reg, underflow_reg;
    logic             is_empty, is_full;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_word;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    stack_dec_t       dec;

    assign is_empty = (sp_reg == '0);
    assign is_full  = (sp_reg == SP_FULL);
    // Wraps to DEPTH-1 when empty; the read is masked by is_empty below.
    assign top_addr = sp_reg[AW-1:0] - AW'(1);
    assign dec      = decode_op(push, pop, is_empty, is_full);

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (write_data),
        .raddr (top_addr),
        .rdata (top_word)
    );

    always_comb begin
        sp_next        = sp_reg;
        read_data_next = read_data_reg;
        mem_we         = 1'b0;
        mem_waddr      = sp_reg[AW-1:0];
        case (dec.op)
            OP_PUSH: begin
                mem_we  = 1'b1;
                sp_next = sp_reg + SP_ONE;
            end
            OP_POP: begin
                read_data_next = top_word;
                sp_next        = sp_reg - SP_ONE;
            end
            OP_REPLACE: begin
                mem_we         = 1'b1;
                mem_waddr      = top_addr;
                read_data_next = top_word;
            end
            default: begin
                sp_next = sp_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_reg        <= '0;
            read_data_reg <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            read_data_reg <= read_data_next;
            overflow_reg  <= dec.overflow;
            underflow_reg <= dec.underflow;
        end
    end

    assign read_data = read_data_reg;
    assign top_data  = is_empty ? '0 : top_word;
    assign count     = sp_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_param_stack.sv
// Directed and model-checked bench for param_stack at WIDTH=8, DEPTH=4.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] write_data = '0;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] top_data;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .top_data   (top_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one request, then sample just after the accepting edge.
    task automatic cycle(input logic p, input logic q, input logic [WIDTH-1:0] d);
        push       = p;
        pop        = q;
        write_data = d;
        @(posedge clk);
        #1;
        $display("txn push=%0b pop=%0b wd=%h -> rd=%h top=%h cnt=%0d e=%0b f=%0b ov=%0b uf=%0b",
                 p, q, d, read_data, top_data, count, empty, full, overflow, underflow);
    endtask

    logic [WIDTH-1:0] q_model[$];
    logic [WIDTH-1:0] exp_rd;
    logic             exp_ov, exp_uf;

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #1;
        check_val("rst_count", 32'(count), 0);
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_full", 32'(full), 0);
        check_val("rst_top", 32'(top_data), 0);
        check_val("rst_rd", 32'(read_data), 0);
        check_val("rst_flags", {30'd0, overflow, underflow}, 0);
        #8 reset = 1'b1;

        // Fill to capacity
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            check_val($sformatf("fill_count%0d", i), 32'(count), 32'(i));
            check_val($sformatf("fill_top%0d", i), 32'(top_data), 32'(i));
            check_val($sformatf("fill_full%0d", i), 32'(full), (i == 4) ? 32'd1 : 32'd0);
        end

        // Overflow pulse lasts one cycle
        cycle(1'b1, 1'b0, 8'h05);
        check_val("ovf_pulse", 32'(overflow), 1);
        check_val("ovf_count", 32'(count), 4);
        check_val("ovf_top", 32'(top_data), 32'h04);
        cycle(1'b0, 1'b0, 8'hx);
        check_val("ovf_clear", 32'(overflow), 0);
        check_val("idle_xdata_top", 32'(top_data), 32'h04);

        // Drain, with undriven write data on pop cycles
        for (int i = 4; i >= 1; i--) begin
            cycle(1'b0, 1'b1, 8'hx);
            check_val($sformatf("drain_rd%0d", i), 32'(read_data), 32'(i));
            check_val($sformatf("drain_cnt%0d", i), 32'(count), 32'(i - 1));
        end
        check_val("drain_empty", 32'(empty), 1);
        check_val("drain_top", 32'(top_data), 0);
        cycle(1'b0, 1'b1, 8'h00);
        check_val("udf_pulse", 32'(underflow), 1);
        check_val("udf_rd_hold", 32'(read_data), 32'h01);
        cycle(1'b0, 1'b0, 8'h00);
        check_val("udf_clear", 32'(underflow), 0);

        // Replace-top
        cycle(1'b1, 1'b0, 8'h01);
        cycle(1'b1, 1'b0, 8'h02);
        cycle(1'b1, 1'b1, 8'hAA);
        check_val("rep_rd", 32'(read_data), 32'h02);
        check_val("rep_top", 32'(top_data), 32'hAA);
        check_val("rep_count", 32'(count), 2);
        check_val("rep_flags", {30'd0, overflow, underflow}, 0);
        cycle(1'b0, 1'b1, 8'h00);
        check_val("rep_pop1", 32'(read_data), 32'hAA);
        cycle(1'b0, 1'b1, 8'h00);
        check_val("rep_pop2", 32'(read_data), 32'h01);

        // Push+pop on empty acts as push with underflow
        cycle(1'b1, 1'b1, 8'h55);
        check_val("pp_empty_count", 32'(count), 1);
        check_val("pp_empty_top", 32'(top_data), 32'h55);
        check_val("pp_empty_udf", 32'(underflow), 1);
        check_val("pp_empty_rd", 32'(read_data), 32'h01);
        cycle(1'b0, 1'b1, 8'h00);
        check_val("pp_pop", 32'(read_data), 32'h55);

        // Asynchronous reset mid-operation
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        push = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("arst_count", 32'(count), 0);
        check_val("arst_empty", 32'(empty), 1);
        check_val("arst_rd", 32'(read_data), 0);
        check_val("arst_top", 32'(top_data), 0);
        #2 reset = 1'b1;
        cycle(1'b0, 1'b1, 8'h00);
        check_val("arst_pop_udf", 32'(underflow), 1);
        check_val("arst_pop_count", 32'(count), 0);

        // Random traffic against a queue model
        exp_rd = '0;
        for (int n = 0; n < 1000; n++) begin
            logic p, q;
            logic [WIDTH-1:0] d;
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            d = 8'($urandom_range(0, 255));
            exp_ov = 1'b0;
            exp_uf = 1'b0;
            if (p && q) begin
                if (q_model.size() == 0) begin
                    q_model.push_back(d);
                    exp_uf = 1'b1;
                end else begin
                    exp_rd = q_model[$];
                    q_model[$] = d;
                end
            end else if (p) begin
                if (q_model.size() == DEPTH) exp_ov = 1'b1;
                else                         q_model.push_back(d);
            end else if (q) begin
                if (q_model.size() == 0) exp_uf = 1'b1;
                else                     exp_rd = q_model.pop_back();
            end
            cycle(p, q, d);
            check_val("rnd_rd", 32'(read_data), 32'(exp_rd));
            check_val("rnd_count", 32'(count), 32'(q_model.size()));
            check_val("rnd_top", 32'(top_data), (q_model.size() == 0) ? 32'd0 : 32'(q_model[$]));
            check_val("rnd_empty", 32'(empty), (q_model.size() == 0) ? 32'd1 : 32'd0);
            check_val("rnd_full", 32'(full), (q_model.size() == DEPTH) ? 32'd1 : 32'd0);
            check_val("rnd_ovf", 32'(overflow), 32'(exp_ov));
            check_val("rnd_udf", 32'(underflow), 32'(exp_uf));
            check_val("rnd_sp_max", 32'(count <= 3'(DEPTH)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, stack capacity in words (power of 2, >=2); AW = $clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 push  input  1  push request, sampled on rising clk.
REQ-006 pop  input  1  pop request, sampled on rising clk.
REQ-007 write_data  input  WIDTH  word to push.
REQ-008 read_data  output  WIDTH  registered word from the last accepted pop.
REQ-009 top_data  output  WIDTH  combinational peek of the current top of stack; 0 when empty.
REQ-010 count  output  AW+1  number of stored words, 0..DEPTH.
REQ-011 empty  output  1  high when count==0.
REQ-012 full  output  1  high when count==DEPTH.
REQ-013 overflow  output  1  one-cycle pulse, registered: rejected push.
REQ-014 underflow  output  1  one-cycle pulse, registered: rejected pop.

Function
REQ-015 Storage: DEPTH x WIDTH array; stack pointer sp (AW+1 bits) equals count; top entry at index sp-1.
REQ-016 Push only, not full: mem[sp] <= write_data; sp <= sp+1; read_data holds.
REQ-017 Push only, full: no storage or sp change; overflow=1 for the following cycle.
REQ-018 Pop only, not empty: read_data <= mem[sp-1]; sp <= sp-1; popped entry is not cleared.
REQ-019 Pop only, empty: no change; read_data holds; underflow=1 for the following cycle.
REQ-020 Push+pop, not empty (including full): replace-top; read_data <= old mem[sp-1]; mem[sp-1] <= write_data; sp unchanged; no overflow.
REQ-021 Push+pop, empty: treated as push only (REQ-016); underflow=1 for the following cycle.
REQ-022 Neither push nor pop: all state holds; overflow and underflow return to 0.
REQ-023 Pop latency: popped word on read_data one cycle after the accepting edge; top_data reflects the new top in the same cycle as the count update.
REQ-024 empty, full and top_data are decoded from sp and the array; they do not lag sp.
REQ-025 Pointer never wraps: sp stays in 0..DEPTH under any input sequence.
REQ-026 X or undriven write_data on a cycle without an accepted push does not affect state.

Reset
REQ-027 reset=0 asynchronously forces sp=0, read_data=0, overflow=0, underflow=0; empty=1, full=0, count=0, top_data=0.
REQ-028 Array contents are not reset; they are unobservable until rewritten.
REQ-029 Reset asserted mid-operation discards the stored contents; the first edge after deassertion behaves as from empty.
REQ-030 push and pop are ignored while reset=0.

Structure
REQ-031 Shared package stack_pkg holds the default WIDTH and DEPTH constants and the op-code encoding {IDLE, PUSH, POP, REPLACE} used for the decode.
REQ-032 Sub-module stack_regfile: DEPTH x WIDTH array with one synchronous write port and one asynchronous read port (address sp-1), no reset.
REQ-033 The top level holds the sp counter, op decode, read_data register, flag logic and error pulses.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset, then push 01,02,03,04 -> count 1..4; full=1 after the 4th push; top_data=04.
REQ-035 From full, push 05 -> overflow=1 for exactly one cycle; count=4; top_data=04.
REQ-036 From full, pop 4 times -> read_data 04,03,02,01 on successive cycles; empty=1 afterwards; a 5th pop gives underflow=1, read_data stays 01.
REQ-037 Stack {01,02}, push+pop with write_data=AA -> read_data=02, top_data=AA, count=2; on an empty stack, push+pop with 55 -> count=1, top_data=55, underflow=1.
REQ-038 Push 11,22, then assert reset between clk edges -> count=0, empty=1, and read_data=0 before the next edge; after deassertion, pop -> underflow=1.
REQ-039 Random push/pop for 1000 cycles against a reference model -> read_data, count and flags match on every cycle; sp never exceeds 4.
